// File: rtl/controlsgs.sv
// Shared pipeline control-signal definitions for the Zeptron core.
// Each pipeline stage register pulls these in, so a bubble looks the same
// in every stage.
//   controlsgs_t      : packed control bundle produced by decode and
//                       forwarded down the pipeline
//   CONTROLSGS_BUBBLE : all-zero bundle. It writes nothing, reads nothing
//                       and never branches, so it is safe to insert anywhere.
// The include guard lets this file be compiled on its own and also be
// `included by the stage registers, in either order.
`ifndef ZEPTRON_CONTROLSGS_SV
`define ZEPTRON_CONTROLSGS_SV

package controlsgs_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } controlsgs_t;

  localparam controlsgs_t CONTROLSGS_BUBBLE = '0;

endpackage

`endif

// File: rtl/pipe_reg.sv
// Generic pipeline stage flop. It is shared by every stage register in the
// core.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset; loads RST_VAL
//   clr_i : synchronous clear (flush); loads RST_VAL; lower priority than rst_i
//   en_i  : capture d_i when high, hold when low
//   d_i   : WIDTH-bit input
//   q_o   : WIDTH-bit registered output
module pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Reset and clear both load the bubble value, so the order between them
  // does not change the result. Either one overrides enable.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) q_q <= RST_VAL;
    else if (en_i)      q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_dm_register.sv
// EX->DM pipeline register of the Zeptron RISC-V core.
// It captures the ALU result and the control bundle on each enabled edge.
// Stall holds the current values. Reset (and flush, when built in) inserts
// a bubble.
//   clk          : pipeline clock
//   reset        : synchronous active-high reset; loads a bubble
//   enable       : 1 = capture e_* this edge, 0 = stall
//   flush        : only present with EX_DM_FLUSH_EN defined. It squashes
//                  the EX instruction into a bubble and ignores enable.
//   e_alu_y      : ALU result from EX
//   e_controlsgs : control bundle from EX
//   m_alu_y      : registered ALU result to DM
//   m_controlsgs : registered control bundle to DM
// Build option: define EX_DM_FLUSH_EN to add the flush port.
`include "controlsgs.sv"

module ex_dm_register
  import controlsgs_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
`ifdef EX_DM_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [DATA_WIDTH-1:0] e_alu_y,
  input  controlsgs_t           e_controlsgs,
  output logic [DATA_WIDTH-1:0] m_alu_y,
  output controlsgs_t           m_controlsgs
);

  localparam int CTL_W = $bits(controlsgs_t);

  logic             clr;
  logic [CTL_W-1:0] ctl_q;

`ifdef EX_DM_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  pipe_reg #(
    .WIDTH   (DATA_WIDTH),
    .RST_VAL ('0)
  ) u_alu_y (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (clr),
    .en_i  (enable),
    .d_i   (e_alu_y),
    .q_o   (m_alu_y)
  );

  // The struct travels as one packed vector, so every field is copied
  // bit-exact and no field is gated on its own.
  pipe_reg #(
    .WIDTH   (CTL_W),
    .RST_VAL (CONTROLSGS_BUBBLE)
  ) u_ctl (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (clr),
    .en_i  (enable),
    .d_i   (e_controlsgs),
    .q_o   (ctl_q)
  );

  assign m_controlsgs = controlsgs_t'(ctl_q);

endmodule

// File: tb/tb_ex_dm_register.sv
// Scoreboard bench for ex_dm_register.
// The driver applies one edge's worth of inputs. Right after that edge it
// queues the hand-computed expected outputs. A separate monitor pops the
// queue on the falling edge and compares the values.
module tb_ex_dm_register;
  import controlsgs_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] alu;
    controlsgs_t ctl;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] e_alu_y;
  controlsgs_t e_controlsgs;
  logic [31:0] m_alu_y;
  controlsgs_t m_controlsgs;
`ifdef EX_DM_FLUSH_EN
  logic        flush;
`endif

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ex_dm_register #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
`ifdef EX_DM_FLUSH_EN
    .flush        (flush),
`endif
    .e_alu_y      (e_alu_y),
    .e_controlsgs (e_controlsgs),
    .m_alu_y      (m_alu_y),
    .m_controlsgs (m_controlsgs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control constants, field order: rw mw mr m2r as br j alu_op[2:0]
  localparam logic [9:0] CTL_ONES101 = 10'b1111111_101;
  localparam logic [9:0] CTL_ZERO    = 10'b0000000_000;
  localparam logic [9:0] CTL_MIX     = 10'b1010010_011;
  localparam logic [9:0] CTL_MIX2    = 10'b0101101_110;

  // Monitor: compares the queued expectation against the registered outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (m_alu_y !== e.alu) begin
        failures++;
        $display("FAIL %s alu_y: got %h expected %h", e.name, m_alu_y, e.alu);
      end
      checks++;
      if (m_controlsgs !== e.ctl) begin
        failures++;
        $display("FAIL %s ctl: got %b expected %b", e.name, m_controlsgs, e.ctl);
      end
    end
  end

  // Drive inputs on the falling edge, let one rising edge happen, then queue
  // the expected outputs for the monitor to check at the next falling edge.
  task automatic step(input string nm, input logic rst, input logic en,
                      input logic fl, input logic [31:0] a, input logic [9:0] c,
                      input logic [31:0] ea, input logic [9:0] ec);
    exp_t e;
    @(negedge clk);
    #1;
    reset        = rst;
    enable       = en;
`ifdef EX_DM_FLUSH_EN
    flush        = fl;
`endif
    e_alu_y      = a;
    e_controlsgs = controlsgs_t'(c);
    @(posedge clk);
    #1;
    // Wiggle inputs between edges. The outputs must not follow them.
    e_alu_y      = ~a;
    e_controlsgs = controlsgs_t'(~c);
    e.name = nm;
    e.alu  = ea;
    e.ctl  = controlsgs_t'(ec);
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; e_alu_y = '0; e_controlsgs = '0;
`ifdef EX_DM_FLUSH_EN
    flush = 1'b0;
`endif
    // 1: reset with live inputs and enable high
    step("reset",     1, 1, 0, 32'hDEADBEEF, CTL_ONES101, 32'h0,        CTL_ZERO);
    // 2: capture
    step("capture",   0, 1, 0, 32'h000000A1, CTL_ONES101, 32'h000000A1, CTL_ONES101);
    // 3: stall for three edges
    for (int i = 0; i < 3; i++)
      step("stall",   0, 0, 0, 32'h12345678, CTL_ZERO,    32'h000000A1, CTL_ONES101);
    // 4: reset beats enable, then normal capture resumes
    step("rst_ovr",   1, 1, 0, 32'h00000055, CTL_MIX,     32'h0,        CTL_ZERO);
    step("post_rst",  0, 1, 0, 32'h00000055, CTL_MIX,     32'h00000055, CTL_MIX);
    // 5: back-to-back captures
    step("b2b1",      0, 1, 0, 32'h00000001, CTL_MIX2,    32'h00000001, CTL_MIX2);
    step("b2b2",      0, 1, 0, 32'h00000002, CTL_MIX,     32'h00000002, CTL_MIX);
    step("b2b3",      0, 1, 0, 32'h00000003, CTL_ONES101, 32'h00000003, CTL_ONES101);
    // Full-width data and a hold after a stall
    step("wide",      0, 1, 0, 32'hFFFFFFFF, CTL_MIX2,    32'hFFFFFFFF, CTL_MIX2);
    step("hold_wide", 0, 0, 0, 32'h0,        CTL_ZERO,    32'hFFFFFFFF, CTL_MIX2);
`ifdef EX_DM_FLUSH_EN
    // 6: flush while stalled gives a bubble; reset and flush together also give a bubble
    step("pre_fl",    0, 1, 0, 32'h00000099, CTL_ONES101, 32'h00000099, CTL_ONES101);
    step("flush",     0, 0, 1, 32'h00000077, CTL_MIX,     32'h0,        CTL_ZERO);
    step("fl_en",     0, 1, 0, 32'h00000042, CTL_MIX,     32'h00000042, CTL_MIX);
    step("fl_en1",    0, 1, 1, 32'h00000043, CTL_MIX2,    32'h0,        CTL_ZERO);
    step("rst_fl",    1, 1, 1, 32'h00000077, CTL_MIX,     32'h0,        CTL_ZERO);
`endif
    // Drain the scoreboard, with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
